// File: rtl/fifo_stream_reader_if.sv
// Valid/ready output stream of fifo_stream_reader: word, valid, ready and
// frame-last marker.
interface fifo_stream_reader_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;
  logic                  m_last;

  modport master (output m_data, output m_valid, output m_last, input m_ready);
  modport slave  (input m_data, input m_valid, input m_last, output m_ready);
endinterface

// File: rtl/fifo_stream_reader.sv
// Drains the single-clock fifo into a 2-entry head/skid buffer and a valid/ready stream.
// Optional frame-last generation is enabled by defining FIFO_RD_LAST_EN.
module fifo_stream_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int FRAME_LEN  = 80
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_re,
  output logic [1:0]            buf_count,
  fifo_stream_reader_if.master  m
);

  if (FRAME_LEN < 2) begin : g_bad_frame_len
    $error("fifo_stream_reader: FRAME_LEN must be at least 2");
  end

  logic                  inflight_q, inflight_d;
  logic [1:0]            count_q, count_d;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] skid_q, skid_d;
  logic                  pop;
  logic [2:0]            credit;

  always_comb begin
    pop        = (count_q != 2'd0) && m.m_ready;
    // credit is the buffer occupancy after this edge, counting the word in flight
    credit     = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    fifo_re    = en && !fifo_empty && (credit < 3'd2);
    inflight_d = fifo_re;
    count_d    = credit[1:0];
    head_d     = head_q;
    skid_d     = skid_q;
    if (pop && count_q == 2'd2) head_d = skid_q;
    if (inflight_q) begin
      if (count_q == 2'd0 || (count_q == 2'd1 && pop)) head_d = fifo_data;
      else                                               skid_d = fifo_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q <= 1'b0;
      count_q    <= 2'd0;
      head_q     <= '0;
      skid_q     <= '0;
    end else begin
      inflight_q <= inflight_d;
      count_q    <= count_d;
      head_q     <= head_d;
      skid_q     <= skid_d;
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (rst_n) begin
      assert (!(inflight_q && count_q == 2'd2 && !pop))
        else $error("fifo_stream_reader: capture into a full buffer");
    end
  end
`endif

  assign m.m_valid = (count_q != 2'd0);
  assign m.m_data  = head_q;
  assign buf_count = count_q;

`ifdef FIFO_RD_LAST_EN
  localparam int            CW        = $clog2(FRAME_LEN);
  localparam logic [CW-1:0] LAST_BEAT = CW'(FRAME_LEN - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Counts accepted beats only, so a stalled last beat keeps m_last high.
  always_comb begin
    cnt_d = cnt_q;
    if (pop) cnt_d = (cnt_q == LAST_BEAT) ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign m.m_last = m.m_valid && (cnt_q == LAST_BEAT);
`else
  assign m.m_last = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Scoreboard bench for fifo_stream_reader: a behavioural fifo feeds the DUT, writes push
// expected words, and a negedge monitor checks every accepted beat and m_last.
module tb_fifo_stream_reader;
  localparam int DW = 8;
  localparam int FL = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          fifo_empty = 1'b1;
  logic [DW-1:0] fifo_data = '0;
  logic          fifo_re;
  logic [1:0]    buf_count;
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;

  fifo_stream_reader_if #(.DATA_WIDTH(DW)) sif ();

  fifo_stream_reader #(.DATA_WIDTH(DW), .FRAME_LEN(FL)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .fifo_empty(fifo_empty),
    .fifo_data (fifo_data),
    .fifo_re   (fifo_re),
    .buf_count (buf_count),
    .m         (sif.master)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int beat   = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] fq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_chk++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp_v, $time);
  endtask

  function automatic bit exp_last(input int b);
`ifdef FIFO_RD_LAST_EN
    return (b % FL) == FL - 1;
`else
    return 1'b0;
`endif
  endfunction

  // Behavioural fifo: data_out registered on re, occupancy updated on the same edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fq.delete();
      fifo_empty <= 1'b1;
      fifo_data  <= '0;
    end else begin
      if (fifo_re && fq.size() != 0) fifo_data <= fq.pop_front();
      if (wr_en) fq.push_back(wr_data);
      fifo_empty <= (fq.size() == 0);
    end
  end

  // Monitor: sampled on the falling edge, away from the DUT's active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (fifo_re) chk("re_while_empty", {31'd0, fifo_empty}, 32'd0);
      if (sif.m_valid) begin
        chk("m_last", {31'd0, sif.m_last}, {31'd0, exp_last(beat)});
        if (sif.m_ready) begin
          if (exp_q.size() == 0) chk("unexpected_beat", {24'd0, sif.m_data}, 32'hFFFF_FFFF);
          else                   chk("m_data", {24'd0, sif.m_data}, {24'd0, exp_q.pop_front()});
          beat++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [DW-1:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    exp_q.push_back(d);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic drain(input bit rnd);
    for (int c = 0; c < 4000 && (exp_q.size() != 0 || buf_count != 2'd0); c++) begin
      sif.m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
    end
    sif.m_ready = 1'b1;
    chk("drain_complete", {31'd0, (exp_q.size() == 0 && buf_count == 2'd0)}, 32'd1);
  endtask

  initial begin
    int re_cnt, re_at, v_at, v_cnt, run, w;
    sif.m_ready = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Reset values
    @(negedge clk);
    chk("rst_m_valid", {31'd0, sif.m_valid}, 32'd0);
    chk("rst_m_data", {24'd0, sif.m_data}, 32'd0);
    chk("rst_m_last", {31'd0, sif.m_last}, 32'd0);
    chk("rst_buf_count", {30'd0, buf_count}, 32'd0);
    chk("rst_fifo_re", {31'd0, fifo_re}, 32'd0);

    // Basic latency: one word, pop to stream in 2 cycles
    tick();
    en = 1'b1; sif.m_ready = 1'b1;
    wr(8'hA5);
    re_cnt = 0; re_at = -1; v_at = -1; v_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (fifo_re) begin re_cnt++; if (re_at < 0) re_at = k; end
      if (sif.m_valid) begin v_cnt++; if (v_at < 0) v_at = k; end
    end
    chk("basic_re_pulses", re_cnt, 1);
    chk("basic_latency", v_at - re_at, 2);
    chk("basic_valid_cycles", v_cnt, 1);
    chk("basic_buf_empty", {30'd0, buf_count}, 32'd0);

    // Streaming: 16 preloaded words, no gaps after the first beat
    tick();
    en = 1'b0;
    for (int i = 0; i < 16; i++) wr(8'(i));
    en = 1'b1;
    run = 0;
    for (int k = 0; k < 10 && !sif.m_valid; k++) @(negedge clk);
    for (int k = 0; k < 16; k++) begin
      if (sif.m_valid) run++;
      @(negedge clk);
    end
    chk("stream_run", run, 16);
    chk("stream_done", {31'd0, sif.m_valid}, 32'd0);
    tick();

    // Backpressure: 8 words, ready low for 10 cycles
    sif.m_ready = 1'b0;
    for (int i = 0; i < 8; i++) wr(8'(i));
    repeat (10) tick();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_buf_count", {30'd0, buf_count}, 32'd2);
      chk("bp_fifo_re", {31'd0, fifo_re}, 32'd0);
      chk("bp_m_data", {24'd0, sif.m_data}, 32'd0);
    end
    tick();
    drain(1'b0);

    // Random ready with random writes, 1000 words
    w = 0;
    while (w < 1000) begin
      sif.m_ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) begin wr(8'(w * 7 + 3)); w++; end
      else tick();
    end
    drain(1'b1);

    // Asynchronous reset with a full buffer
    sif.m_ready = 1'b0;
    wr(8'h31); wr(8'h32); wr(8'h33);
    repeat (3) tick();
    @(negedge clk);
    chk("pre_rst_buf_count", {30'd0, buf_count}, 32'd2);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_m_valid", {31'd0, sif.m_valid}, 32'd0);
    chk("arst_m_data", {24'd0, sif.m_data}, 32'd0);
    chk("arst_m_last", {31'd0, sif.m_last}, 32'd0);
    chk("arst_buf_count", {30'd0, buf_count}, 32'd0);
    chk("arst_fifo_re", {31'd0, fifo_re}, 32'd0);
    exp_q.delete();
    beat = 0;
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Frame of 12 words with random stalls; m_last on beats 4, 8, 12
    for (int i = 0; i < 12; i++) begin
      sif.m_ready = 1'($urandom_range(0, 1));
      wr(8'(8'h40 + i));
    end
    drain(1'b1);
    chk("frame_beats", beat, 12);

    // en low with a non-empty fifo: no pops
    en = 1'b0;
    wr(8'h51); wr(8'h52); wr(8'h53);
    re_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (fifo_re) re_cnt++;
    end
    chk("en_low_no_re", re_cnt, 0);
    tick();
    en = 1'b1;
    drain(1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fifo_stream_reader.md
# fifo_stream_reader

Drain side of the single-clock `fifo`. It issues `re` pops only when the FIFO is non-empty, and absorbs the FIFO's one-cycle read latency. Popped words go into a 2-entry output buffer and are presented on a valid/ready stream to downstream logic, such as the miner header/nonce loader. Sustained throughput is one word per clock.

## Interface
- `DATA_WIDTH`, 8: word width; must match the attached `fifo`.
- `FRAME_LEN`, 80: beats per frame for `m_last` generation; must be ≥ 2. Used only with `FIFO_RD_LAST_EN`.

- `clk`  in  1  single clock, all state on rising edge.
- `rst_n`  in  1  asynchronous active-low reset; one clock; reset is asynchronous and active-low.
- `en`  in  1  high: new pops may be issued; low: no new pops, in-flight word still captured.
- `fifo_empty`  in  1  from `fifo.empty`.
- `fifo_data`  in  DATA_WIDTH  from `fifo.data_out`; valid the cycle after `fifo_re`.
- `fifo_re`  out  1  to `fifo.re`; one pop per cycle high.
- `m_data`  out  DATA_WIDTH  stream word (registered).
- `m_valid`  out  1  stream word valid.
- `m_ready`  in  1  downstream accept.
- `m_last`  out  1  final beat of a frame; constant 0 when `FIFO_RD_LAST_EN` is undefined.
- `buf_count`  out  2  words held in the output buffer (0..2).

## Operation
- **State**
  - `inflight` (1 bit): a pop was issued last cycle.
  - Buffer of 2 entries, with a head register driving `m_data` and a skid register.
  - `buf_count`.
- **Accept:** `pop = m_valid && m_ready`.
- **Credit:** `credit = buf_count + inflight - pop`.
- **Pop issue:** `fifo_re = en && !fifo_empty && (credit < 2)`.
  - This is combinational from registers and inputs.
  - `fifo_re` must never be high while `fifo_empty` is high: the FIFO advances its read pointer unconditionally on `re`.
- **Capture:** when `inflight` is 1, `fifo_data` is written into the buffer this cycle.
  - Buffer empty, or buffer has 1 word being popped: the word goes to head.
  - Otherwise: the word goes to skid.
- **Pop:** on `pop`, skid moves to head if occupied; else head empties.
- **Simultaneous capture + pop**
  - `buf_count` is unchanged.
  - Head takes skid if skid is occupied, else takes the captured word.
  - Order is preserved.
- **Overflow:** impossible by credit rule. A capture with `buf_count==2` and no pop is a design error; flag it with a simulation assertion.
- **`m_valid` = (`buf_count != 0`).** `m_data` holds steady while `m_valid && !m_ready`.
- **`en` deassert:** buffered and in-flight words still drain to the stream; no new pops.
- **Reset mid-operation:**
  - Buffer, `inflight` and frame counter clear.
  - Any word in flight is discarded.
  - The FIFO must be reset on the same `rst_n`.

## Timing
- **Reset values:** `fifo_re`=0 (since `buf_count`=0, `inflight`=0, only driven by inputs after release, and gated by `en`/`fifo_empty`); `m_valid`=0; `m_data`=0; `m_last`=0; `buf_count`=0.
- **Latency:** with `fifo_re` in cycle N, the word is visible as `m_valid`/`m_data` in cycle N+2, i.e. 2 cycles from pop to stream.
- **Throughput:** 1 word/cycle while FIFO is non-empty and `m_ready`=1, with `buf_count`=1 and `inflight`=1 steady state.
- **Backpressure:**
  - `m_ready`=0 for ≥2 cycles: at most 2 words buffered, `fifo_re` held low.
  - Resumes the cycle `credit` drops below 2.
- **`fifo_empty`:** sampled combinationally. The FIFO's occupancy updates at the same edge as `re`, so no extra guard cycle is needed.

## Configuration
- **`FIFO_RD_LAST_EN` defined**
  - Frame beat counter, `$clog2(FRAME_LEN)` bits, reset 0.
  - Increments on each `pop` and wraps from `FRAME_LEN-1` to 0.
  - `m_last = m_valid && (cnt == FRAME_LEN-1)`.
  - The counter does not advance on stalled beats.
- **`FIFO_RD_LAST_EN` undefined:** no counter is instantiated; `m_last` is tied 0.

## Test plan
- **Basic latency:** reset, write 1 word 0xA5 into FIFO, `en`=1, `m_ready`=1.
  - Expect exactly one `fifo_re` pulse.
  - Expect `m_valid` 2 cycles later with `m_data`=0xA5 for one cycle.
  - Expect `buf_count` back to 0.
- **Streaming:** preload 16 words 0x00..0x0F, `m_ready`=1.
  - Expect 16 consecutive `m_valid` beats in order, no gaps after first.
  - Expect `fifo_re` never high with `fifo_empty`=1.
- **Backpressure:** preload 8 words, `m_ready`=0 for 10 cycles, then 1.
  - Expect `buf_count`=2 and `fifo_re` low while stalled.
  - Expect `m_data`=0x00 held.
  - Expect all 8 words out in order with no loss or duplication.
- **Random `m_ready` (50%) with random FIFO writes, 1000 words:** scoreboard matches order exactly; FIFO `occupants` never underflows.
- **Reset and `en`:**
  - Assert `rst_n`=0 mid-stream with `buf_count`=2: all outputs go to reset values immediately (asynchronous).
  - With `en`=0 and FIFO non-empty: no `fifo_re`.
- **`FIFO_RD_LAST_EN` with `FRAME_LEN`=4, 12 words, random stalls:** `m_last` high on beats 4, 8, 12 only; counter holds during stalls.
